// File: rtl/gouram_ex_pkg.sv
// Shared types for the execute/memory trace tracker.
// Record layout, FSM states and the default repeat marker word.
package gouram_ex_pkg;

   localparam int TIME_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;

   localparam logic [31:0] REPEAT_MARKER_DEF = 32'h00002083;

   typedef logic [TIME_W_DEF-1:0] time_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

   typedef struct packed {
      time_t t_start;
      time_t t_end;
      addr_t addr;
   } mem_record_t;

   typedef enum logic [1:0] {
      IDLE,
      MATCH,
      OUTPUT
   } ex_state_t;

endpackage

// File: rtl/mem_chan_tracker.sv
// One data-memory channel: pending (granted) and completed FIFOs
// with sticky overflow and protocol-error flags.
module mem_chan_tracker #(
   parameter int AW    = 32,
   parameter int TW    = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [TW-1:0] counter,
   input  logic          req,
   input  logic          gnt,
   input  logic [AW-1:0] addr,
   input  logic          rvalid,
   input  logic          pop_i,
   output logic          head_valid_o,
   output logic [TW-1:0] head_start_o,
   output logic [TW-1:0] head_end_o,
   output logic [AW-1:0] head_addr_o,
   output logic          overflow_o,
   output logic          proto_err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [TW-1:0] t_start;
      logic [AW-1:0] addr;
   } pend_t;

   typedef struct packed {
      logic [TW-1:0] t_start;
      logic [TW-1:0] t_end;
      logic [AW-1:0] addr;
   } rec_t;

   pend_t pend_mem_q [DEPTH];
   rec_t  done_mem_q [DEPTH];

   logic [PW:0]   pend_cnt_q, pend_cnt_d, done_cnt_q, done_cnt_d;
   logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
   logic [PW-1:0] done_wr_q, done_wr_d, done_rd_q, done_rd_d;
   logic          ovf_q, ovf_d, perr_q, perr_d;
   logic          pend_push, pend_pop, done_push, done_pop;
   pend_t         pend_head;
   rec_t          done_wdata;

   always_comb begin
      pend_head  = pend_mem_q[pend_rd_q];
      pend_pop   = rvalid && (pend_cnt_q != '0);
      done_pop   = pop_i && (done_cnt_q != '0);
      // a pop in the same cycle frees a slot for the push
      pend_push  = req && gnt && ((pend_cnt_q != FULL) || pend_pop);
      done_push  = pend_pop && ((done_cnt_q != FULL) || done_pop);
      done_wdata = '{t_start: pend_head.t_start,
                     t_end:   counter,
                     addr:    pend_head.addr};

      ovf_d  = ovf_q || (req && gnt && !pend_push)
                     || (pend_pop && !done_push);
      perr_d = perr_q || (rvalid && (pend_cnt_q == '0));

      pend_wr_d = pend_push ? pend_wr_q + PW'(1) : pend_wr_q;
      pend_rd_d = pend_pop  ? pend_rd_q + PW'(1) : pend_rd_q;
      done_wr_d = done_push ? done_wr_q + PW'(1) : done_wr_q;
      done_rd_d = done_pop  ? done_rd_q + PW'(1) : done_rd_q;

      pend_cnt_d = pend_cnt_q;
      if (pend_push && !pend_pop) pend_cnt_d = pend_cnt_q + (PW+1)'(1);
      if (!pend_push && pend_pop) pend_cnt_d = pend_cnt_q - (PW+1)'(1);
      done_cnt_d = done_cnt_q;
      if (done_push && !done_pop) done_cnt_d = done_cnt_q + (PW+1)'(1);
      if (!done_push && done_pop) done_cnt_d = done_cnt_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_cnt_q <= '0;
         done_cnt_q <= '0;
         pend_wr_q  <= '0;
         pend_rd_q  <= '0;
         done_wr_q  <= '0;
         done_rd_q  <= '0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         pend_cnt_q <= pend_cnt_d;
         done_cnt_q <= done_cnt_d;
         pend_wr_q  <= pend_wr_d;
         pend_rd_q  <= pend_rd_d;
         done_wr_q  <= done_wr_d;
         done_rd_q  <= done_rd_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
         if (pend_push) pend_mem_q[pend_wr_q] <= '{counter, addr};
         if (done_push) done_mem_q[done_wr_q] <= done_wdata;
      end
   end

   assign head_valid_o = (done_cnt_q != '0);
   assign head_start_o = done_mem_q[done_rd_q].t_start;
   assign head_end_o   = done_mem_q[done_rd_q].t_end;
   assign head_addr_o  = done_mem_q[done_rd_q].addr;
   assign overflow_o   = ovf_q;
   assign proto_err_o  = perr_q;

endmodule

// File: rtl/ex_mem_tracker.sv
// Pairs decoded trace elements with completed data-memory
// transactions across several channels, one output per element.
module ex_mem_tracker
   import gouram_ex_pkg::*;
#(
   parameter int          DATA_ADDR_WIDTH   = 32,
   parameter int          NUM_CHANNELS      = 2,
   parameter int          OUTSTANDING_DEPTH = 4,
   parameter int          TIME_WIDTH        = 32,
   parameter logic [31:0] REPEAT_MARKER     = REPEAT_MARKER_DEF,
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [TIME_WIDTH-1:0]                   counter,
   input  logic                                    trace_valid_i,
   output logic                                    trace_ready_o,
   input  logic [31:0]                             trace_instr_i,
   input  logic                                    trace_mem_i,
   input  logic [CW-1:0]                           trace_chan_i,
   input  logic [TIME_WIDTH-1:0]                   trace_dec_end_i,
   input  logic [NUM_CHANNELS-1:0]                 data_mem_req,
   input  logic [NUM_CHANNELS-1:0]                 data_mem_gnt,
   input  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0] data_mem_addr,
   input  logic [NUM_CHANNELS-1:0]                 data_mem_rvalid,
   output logic                                    trace_valid_o,
   input  logic                                    trace_ready_i,
   output logic [31:0]                             ex_instr_o,
   output logic [TIME_WIDTH-1:0]                   ex_dec_end_o,
   output logic [DATA_ADDR_WIDTH-1:0]              ex_mem_addr_o,
   output logic [TIME_WIDTH-1:0]                   ex_mem_start_o,
   output logic [TIME_WIDTH-1:0]                   ex_mem_end_o,
   output logic                                    repeat_detected_o,
   output logic [NUM_CHANNELS-1:0]                 overflow_o,
   output logic [NUM_CHANNELS-1:0]                 proto_err_o
);

   localparam int AW = DATA_ADDR_WIDTH;
   localparam int TW = TIME_WIDTH;
   localparam logic [CW:0] NCH = (CW+1)'(NUM_CHANNELS);

   ex_state_t               state_q, state_d;
   logic [31:0]             instr_q, instr_d;
   logic [TW-1:0]           dec_end_q, dec_end_d;
   logic [CW-1:0]           chan_q, chan_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [TW-1:0]           start_q, start_d;
   logic [TW-1:0]           end_q, end_d;
   logic                    rep_q, rep_d;
   logic                    pop_d;

   logic [NUM_CHANNELS-1:0] head_valid, chan_pop;
   logic [TW-1:0]           head_start [NUM_CHANNELS];
   logic [TW-1:0]           head_end   [NUM_CHANNELS];
   logic [AW-1:0]           head_addr  [NUM_CHANNELS];
   logic                    sel_valid;
   logic [TW-1:0]           sel_start, sel_end;
   logic [AW-1:0]           sel_addr;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      mem_chan_tracker #(
         .AW    (AW),
         .TW    (TW),
         .DEPTH (OUTSTANDING_DEPTH)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .counter      (counter),
         .req          (data_mem_req[c]),
         .gnt          (data_mem_gnt[c]),
         .addr         (data_mem_addr[c*AW +: AW]),
         .rvalid       (data_mem_rvalid[c]),
         .pop_i        (chan_pop[c]),
         .head_valid_o (head_valid[c]),
         .head_start_o (head_start[c]),
         .head_end_o   (head_end[c]),
         .head_addr_o  (head_addr[c]),
         .overflow_o   (overflow_o[c]),
         .proto_err_o  (proto_err_o[c])
      );
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_start = '0;
      sel_end   = '0;
      sel_addr  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         chan_pop[c] = pop_d && (chan_q == CW'(c));
         if (chan_q == CW'(c)) begin
            sel_valid = head_valid[c];
            sel_start = head_start[c];
            sel_end   = head_end[c];
            sel_addr  = head_addr[c];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      dec_end_d = dec_end_q;
      chan_d    = chan_q;
      addr_d    = addr_q;
      start_d   = start_q;
      end_d     = end_q;
      rep_d     = 1'b0;
      pop_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (trace_valid_i) begin
               if (trace_instr_i == REPEAT_MARKER) begin
                  rep_d = 1'b1;
               end else begin
                  instr_d   = trace_instr_i;
                  dec_end_d = trace_dec_end_i;
                  chan_d    = trace_chan_i;
                  addr_d    = '0;
                  start_d   = '0;
                  end_d     = '0;
                  if (trace_mem_i && ({1'b0, trace_chan_i} < NCH))
                     state_d = MATCH;
                  else
                     state_d = OUTPUT;
               end
            end
         end
         MATCH: begin
            // records that finished before decode ended are stale
            if (sel_valid) begin
               pop_d = 1'b1;
               if (sel_end >= dec_end_q) begin
                  addr_d  = sel_addr;
                  start_d = sel_start;
                  end_d   = sel_end;
                  state_d = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (trace_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         dec_end_q <= '0;
         chan_q    <= '0;
         addr_q    <= '0;
         start_q   <= '0;
         end_q     <= '0;
         rep_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         dec_end_q <= dec_end_d;
         chan_q    <= chan_d;
         addr_q    <= addr_d;
         start_q   <= start_d;
         end_q     <= end_d;
         rep_q     <= rep_d;
      end
   end

   assign trace_ready_o     = (state_q == IDLE);
   assign trace_valid_o     = (state_q == OUTPUT);
   assign ex_instr_o        = instr_q;
   assign ex_dec_end_o      = dec_end_q;
   assign ex_mem_addr_o     = addr_q;
   assign ex_mem_start_o    = start_q;
   assign ex_mem_end_o      = end_q;
   assign repeat_detected_o = rep_q;

endmodule
